// File: rtl/aurora_cmd_pkg.sv
// Shared constants, word layouts and checksum helper for the Aurora RX command decoder.
package aurora_cmd_pkg;

    localparam logic [7:0] SOF_CMD      = 8'hA5;
    localparam logic [7:0] SOF_RSP      = 8'h5A;

    localparam logic [7:0] OP_WRITE     = 8'h01;
    localparam logic [7:0] OP_READ      = 8'h02;
    localparam logic [7:0] OP_PING      = 8'h03;
    localparam logic [7:0] OP_CLR_STATS = 8'h04;

    localparam logic [7:0] ST_OK        = 8'h00;
    localparam logic [7:0] ST_BAD_OP    = 8'h01;
    localparam logic [7:0] ST_BAD_ADDR  = 8'h02;

    localparam int SOF_LSB  = 56;
    localparam int OP_LSB   = 48;
    localparam int ADDR_LSB = 40;
    localparam int DATA_LSB = 8;

    typedef struct packed {
        logic [7:0]  sof;
        logic [7:0]  op;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [7:0]  status;
    } rsp_word_t;

    // XOR of every byte above the check byte
    function automatic logic [7:0] calc_chk(input logic [63:0] w);
        logic [7:0] c;
        c = '0;
        for (int i = DATA_LSB; i < 64; i += 8) c = c ^ w[i +: 8];
        return c;
    endfunction

endpackage

// File: rtl/aurora_rsp_fifo.sv
// Response FIFO: RAM body plus a registered output word; total occupancy (RAM + output) is DEPTH.
module aurora_rsp_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 64
) (
    input  logic         user_clk_i,
    input  logic         peripheral_aresetn,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_data,
    output logic         o_valid,
    output logic         o_full,
    output logic         o_empty
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr, r_rd_ptr;
    logic [PW:0]   r_mem_cnt;
    logic          r_out_vld;
    logic [W-1:0]  r_out_data;
    logic          w_load;
    logic [PW:0]   w_occ;

    // The output word only changes when it is empty or being taken
    assign w_load  = (r_mem_cnt != '0) && (!r_out_vld || i_pop);
    assign w_occ   = r_mem_cnt + (PW+1)'(r_out_vld);
    assign o_full  = (w_occ == (PW+1)'(DEPTH));
    assign o_empty = !r_out_vld && (r_mem_cnt == '0);
    assign o_valid = r_out_vld;
    assign o_data  = r_out_data;

    always_ff @(posedge user_clk_i) begin
        if (i_push) r_mem[r_wr_ptr] <= i_data;
    end

    always_ff @(posedge user_clk_i or negedge peripheral_aresetn) begin
        if (!peripheral_aresetn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_mem_cnt  <= '0;
            r_out_vld  <= 1'b0;
            r_out_data <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_load) begin
                r_rd_ptr   <= r_rd_ptr + PW'(1);
                r_out_data <= r_mem[r_rd_ptr];
                r_out_vld  <= 1'b1;
            end else if (i_pop) begin
                r_out_vld  <= 1'b0;
            end
            r_mem_cnt <= r_mem_cnt + (PW+1)'(i_push) - (PW+1)'(w_load);
        end
    end

endmodule

// File: rtl/aurora_rx_cmd_decoder.sv
// Aurora RX command decoder: S1 capture, S2 decode, then execute into shadow regs and queue a response.
// Optional: define AURORA_RX_CHECKSUM_EN to verify the check byte (otherwise only SOF is checked).
module aurora_rx_cmd_decoder
    import aurora_cmd_pkg::*;
#(
    parameter int REG_COUNT = 16,
    parameter int RSP_DEPTH = 16,
    parameter int CNT_W     = 16
) (
    input  logic                   user_clk_i,
    input  logic                   peripheral_aresetn,
    input  logic                   channel_up,
    input  logic [63:0]            rx_tdata,
    input  logic                   rx_tvalid,
    output logic [REG_COUNT*32-1:0] ctrl_regs,
    output logic [REG_COUNT-1:0]   wr_strobe,
    output logic [63:0]            rsp_tdata,
    output logic                   rsp_tvalid,
    input  logic                   rsp_tready,
    output logic [31:0]            cmd_cnt,
    output logic [CNT_W-1:0]       err_cnt,
    output logic [CNT_W-1:0]       drop_cnt
);
    localparam int AW = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;

    logic                         r_s1_vld;
    logic [63:0]                  r_s1_word;
    logic                         r_s2_vld, r_s2_well;
    logic [7:0]                   r_s2_op, r_s2_addr;
    logic [31:0]                  r_s2_data;
    logic [REG_COUNT-1:0][31:0]   r_regs;
    logic [REG_COUNT-1:0]         r_wr_strobe;
    logic [31:0]                  r_cmd_cnt;
    logic [CNT_W-1:0]             r_err_cnt, r_drop_cnt;

    logic            w_chk_ok, w_s1_well, w_in_range, w_push, w_pop, w_full, w_drop, w_clr;
    logic [AW-1:0]   w_idx;
    logic [7:0]      w_status;
    logic [31:0]     w_rsp_data;
    rsp_word_t       w_rsp;
    logic            w_unused_fifo_empty;

`ifdef AURORA_RX_CHECKSUM_EN
    assign w_chk_ok = (r_s1_word[7:0] == calc_chk(r_s1_word));
`else
    logic w_unused_chk;
    assign w_unused_chk = ^r_s1_word[7:0];
    assign w_chk_ok     = 1'b1;
`endif
    assign w_s1_well = (r_s1_word[SOF_LSB +: 8] == SOF_CMD) && w_chk_ok;

    always_ff @(posedge user_clk_i or negedge peripheral_aresetn) begin
        if (!peripheral_aresetn) begin
            r_s1_vld  <= 1'b0;
            r_s1_word <= '0;
            r_s2_vld  <= 1'b0;
            r_s2_well <= 1'b0;
            r_s2_op   <= '0;
            r_s2_addr <= '0;
            r_s2_data <= '0;
        end else begin
            r_s1_vld <= rx_tvalid && channel_up;
            if (rx_tvalid && channel_up) r_s1_word <= rx_tdata;
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_s2_well <= w_s1_well;
                r_s2_op   <= r_s1_word[OP_LSB +: 8];
                r_s2_addr <= r_s1_word[ADDR_LSB +: 8];
                r_s2_data <= r_s1_word[DATA_LSB +: 32];
            end
        end
    end

    assign w_in_range = ({24'd0, r_s2_addr} < 32'(REG_COUNT));
    assign w_idx      = r_s2_addr[AW-1:0];

    // Reads see the register file as of this cycle, so a WRITE one cycle ahead is already visible
    always_comb begin
        w_status   = ST_OK;
        w_rsp_data = r_s2_data;
        case (r_s2_op)
            OP_WRITE: if (!w_in_range) w_status = ST_BAD_ADDR;
            OP_READ: begin
                w_rsp_data = w_in_range ? r_regs[w_idx] : '0;
                if (!w_in_range) w_status = ST_BAD_ADDR;
            end
            OP_PING, OP_CLR_STATS: ;
            default: begin
                w_status   = ST_BAD_OP;
                w_rsp_data = '0;
            end
        endcase
        w_rsp = '{sof: SOF_RSP, op: r_s2_op, addr: r_s2_addr, data: w_rsp_data, status: w_status};
    end

    assign w_push = r_s2_vld && r_s2_well;
    assign w_pop  = rsp_tvalid && rsp_tready;
    assign w_drop = w_push && w_full && !w_pop;
    assign w_clr  = w_push && (r_s2_op == OP_CLR_STATS);

    always_ff @(posedge user_clk_i or negedge peripheral_aresetn) begin
        if (!peripheral_aresetn) begin
            r_regs      <= '0;
            r_wr_strobe <= '0;
            r_cmd_cnt   <= '0;
            r_err_cnt   <= '0;
            r_drop_cnt  <= '0;
        end else begin
            r_wr_strobe <= '0;
            if (w_push && (r_s2_op == OP_WRITE) && w_in_range) begin
                r_regs[w_idx]      <= r_s2_data;
                r_wr_strobe[w_idx] <= 1'b1;
            end
            if (w_push) r_cmd_cnt <= r_cmd_cnt + 32'd1;
            if (w_clr) begin
                r_err_cnt  <= '0;
                r_drop_cnt <= '0;
            end else begin
                if (r_s2_vld && !r_s2_well && (r_err_cnt != {CNT_W{1'b1}}))
                    r_err_cnt <= r_err_cnt + CNT_W'(1);
                if (w_drop && (r_drop_cnt != {CNT_W{1'b1}}))
                    r_drop_cnt <= r_drop_cnt + CNT_W'(1);
            end
        end
    end

    aurora_rsp_fifo #(.DEPTH(RSP_DEPTH), .W(64)) u_rsp_fifo (
        .user_clk_i         (user_clk_i),
        .peripheral_aresetn (peripheral_aresetn),
        .i_push             (w_push && !w_drop),
        .i_data             (w_rsp),
        .i_pop              (w_pop),
        .o_data             (rsp_tdata),
        .o_valid            (rsp_tvalid),
        .o_full             (w_full),
        .o_empty            (w_unused_fifo_empty)
    );

    assign ctrl_regs = r_regs;
    assign wr_strobe = r_wr_strobe;
    assign cmd_cnt   = r_cmd_cnt;
    assign err_cnt   = r_err_cnt;
    assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_aurora_rx_cmd_decoder.sv
// Bench for aurora_rx_cmd_decoder: fixed vectors, timing sequences and random bursts vs an in-order command model.
`timescale 1ns/1ps
module tb_aurora_rx_cmd_decoder;
    localparam int RC    = 16;
    localparam int DEPTH = 16;
    localparam int CW    = 16;
    localparam int MAXC  = (1 << CW) - 1;

    logic              clk = 1'b0, rstn = 1'b0, cu = 1'b1, rxv = 1'b0, rdy = 1'b0;
    logic [63:0]       rxd = '0;
    logic [RC*32-1:0]  ctrl_regs;
    logic [RC-1:0]     wr_strobe;
    logic [63:0]       rsp_tdata;
    logic              rsp_tvalid;
    logic [31:0]       cmd_cnt;
    logic [CW-1:0]     err_cnt, drop_cnt;

    always #5 clk = ~clk;

    aurora_rx_cmd_decoder #(.REG_COUNT(RC), .RSP_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .user_clk_i(clk), .peripheral_aresetn(rstn), .channel_up(cu),
        .rx_tdata(rxd), .rx_tvalid(rxv),
        .ctrl_regs(ctrl_regs), .wr_strobe(wr_strobe),
        .rsp_tdata(rsp_tdata), .rsp_tvalid(rsp_tvalid), .rsp_tready(rdy),
        .cmd_cnt(cmd_cnt), .err_cnt(err_cnt), .drop_cnt(drop_cnt));

    int nchk = 0, nerr = 0;
    logic [31:0] m_regs [RC];
    int          m_cmd = 0, m_err = 0, m_drop = 0;
    logic [63:0] exp_q [$];
    bit          mon_en = 1'b0, rdy_rand = 1'b0;

    typedef struct {
        logic [63:0] w;
        bit          has_rsp;
        logic [63:0] rsp;
        int          exp_err;
    } vec_t;
    vec_t tv [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] mk(input logic [7:0] sof, input logic [7:0] op,
                                       input logic [7:0] addr, input logic [31:0] d);
        logic [63:0] w;
        w = {sof, op, addr, d, 8'h00};
        for (int i = 1; i < 8; i++) w[7:0] = w[7:0] ^ w[8*i +: 8];
        return w;
    endfunction

    // Reference: commands take effect strictly in arrival order
    task automatic model(input logic [63:0] w);
        logic [7:0] sof, op, addr, st, x;
        logic [31:0] d, rd;
        bit well;
        sof = w[63:56]; op = w[55:48]; addr = w[47:40]; d = w[39:8];
        x = 8'h00;
        for (int i = 0; i < 8; i++) x = x ^ w[8*i +: 8];
        well = (sof == 8'hA5);
`ifdef AURORA_RX_CHECKSUM_EN
        well = well && (x == 8'h00);
`endif
        if (!well) begin
            if (m_err < MAXC) m_err++;
            return;
        end
        m_cmd++;
        st = 8'h00; rd = d;
        if (op == 8'h01) begin
            if (addr < RC) m_regs[addr] = d; else st = 8'h02;
        end else if (op == 8'h02) begin
            if (addr < RC) rd = m_regs[addr]; else begin rd = 0; st = 8'h02; end
        end else if (op != 8'h03 && op != 8'h04) begin
            st = 8'h01; rd = 0;
        end
        if (exp_q.size() >= DEPTH) begin
            if (m_drop < MAXC) m_drop++;
        end else exp_q.push_back({8'h5A, op, addr, rd, st});
        if (op == 8'h04) begin m_err = 0; m_drop = 0; end
    endtask

    always @(negedge clk) begin
        if (mon_en && rsp_tvalid && rdy) begin
            if (exp_q.size() == 0) begin
                nchk++; nerr++;
                $display("FAIL rsp_unexpected: got %h, expected none", rsp_tdata);
            end else chk("rsp_word", rsp_tdata, exp_q.pop_front());
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rdy_rand) rdy = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send(input logic [63:0] w, input bit up = 1'b1);
        rxd = w; rxv = 1'b1; cu = up;
        if (up) model(w);
        @(posedge clk); #1;
        rxv = 1'b0; cu = 1'b1;
    endtask

    task automatic check_regs(input string name);
        for (int i = 0; i < RC; i++)
            chk($sformatf("%s_reg%0d", name, i), 64'(ctrl_regs[32*i +: 32]), 64'(m_regs[i]));
    endtask

    task automatic check_cnts(input string name);
        chk({name, "_cmd_cnt"}, 64'(cmd_cnt), 64'(m_cmd));
        chk({name, "_err_cnt"}, 64'(err_cnt), 64'(m_err));
        chk({name, "_drop_cnt"}, 64'(drop_cnt), 64'(m_drop));
    endtask

    task automatic wait_drain(input string name);
        int t;
        t = 0;
        idle(4);
        while ((exp_q.size() != 0 || rsp_tvalid) && t < 300) begin idle(1); t++; end
        nchk++;
        if (t >= 300) begin
            nerr++;
            $display("FAIL %s: drain timeout, got %0d responses outstanding, expected 0", name, exp_q.size());
        end
    endtask

    initial begin
        logic [63:0] w;
        bit got;
        logic [63:0] gw;
        int n, r;

        tv[0] = '{mk(8'hA5, 8'h01, 8'h05, 32'h12345678), 1, 64'h5A01051234567800, 0};
        tv[1] = '{mk(8'hA5, 8'h02, 8'h05, 32'h0),        1, 64'h5A02051234567800, 0};
        tv[2] = '{mk(8'hA5, 8'h02, 8'h20, 32'h0),        1, 64'h5A02200000000002, 0};
        tv[3] = '{mk(8'hA5, 8'h7F, 8'h01, 32'h55),       1, 64'h5A7F010000000001, 0};
        tv[4] = '{mk(8'hA5, 8'h03, 8'h02, 32'hCAFEF00D), 1, 64'h5A0302CAFEF00D00, 0};
        tv[5] = '{mk(8'h5A, 8'h01, 8'h01, 32'h1),        0, 64'h0, 1};
`ifdef AURORA_RX_CHECKSUM_EN
        tv[6] = '{mk(8'hA5, 8'h01, 8'h04, 32'h11) ^ 64'h1, 0, 64'h0, 2};
        tv[7] = '{mk(8'hA5, 8'h01, 8'h10, 32'h77),       1, 64'h5A01100000007702, 2};
        tv[8] = '{mk(8'hA5, 8'h02, 8'h03, 32'h0),        1, 64'h5A0203DEADBEEF00, 2};
`else
        tv[6] = '{mk(8'hA5, 8'h01, 8'h04, 32'h11) ^ 64'h1, 1, 64'h5A01040000001100, 1};
        tv[7] = '{mk(8'hA5, 8'h01, 8'h10, 32'h77),       1, 64'h5A01100000007702, 1};
        tv[8] = '{mk(8'hA5, 8'h02, 8'h03, 32'h0),        1, 64'h5A0203DEADBEEF00, 1};
`endif
        tv[9] = '{mk(8'hA5, 8'h04, 8'h00, 32'h0),        1, 64'h5A04000000000000, 0};

        for (int i = 0; i < RC; i++) m_regs[i] = '0;

        // reset state
        idle(3);
        chk("rst_rsp_tvalid", 64'(rsp_tvalid), 64'd0);
        chk("rst_rsp_tdata", rsp_tdata, 64'd0);
        chk("rst_wr_strobe", 64'(wr_strobe), 64'd0);
        check_cnts("rst");
        check_regs("rst");
        rstn = 1'b1; rdy = 1'b1; mon_en = 1'b1;
        idle(2);

        // single WRITE: register/strobe at N+2, response valid at N+3
        rxd = mk(8'hA5, 8'h01, 8'h03, 32'hDEADBEEF); rxv = 1'b1; model(rxd);
        @(posedge clk); #1; rxv = 1'b0;
        idle(1);
        chk("t1_strobe_n1", 64'(wr_strobe), 64'd0);
        chk("t1_reg3_n1", 64'(ctrl_regs[127:96]), 64'd0);
        idle(1);
        chk("t1_reg3_n2", 64'(ctrl_regs[127:96]), 64'hDEADBEEF);
        chk("t1_strobe_n2", 64'(wr_strobe), 64'h0008);
        chk("t1_rsp_vld_n2", 64'(rsp_tvalid), 64'd0);
        idle(1);
        chk("t1_rsp_vld_n3", 64'(rsp_tvalid), 64'd1);
        chk("t1_rsp_n3", rsp_tdata, 64'h5A0103DEADBEEF00);
        chk("t1_strobe_n3", 64'(wr_strobe), 64'd0);
        idle(3);

        // fixed vectors
        for (int i = 0; i < 10; i++) begin
            send(tv[i].w);
            got = 1'b0; gw = '0;
            for (int c = 0; c < 8 && !got; c++) begin
                idle(1);
                if (rsp_tvalid) begin got = 1'b1; gw = rsp_tdata; end
            end
            chk($sformatf("tv%0d_rsp_seen", i), 64'(got), 64'(tv[i].has_rsp));
            if (tv[i].has_rsp && got) chk($sformatf("tv%0d_rsp", i), gw, tv[i].rsp);
            chk($sformatf("tv%0d_err_cnt", i), 64'(err_cnt), 64'(tv[i].exp_err));
            idle(2);
        end
        wait_drain("tv_drain");
        check_cnts("tv");
        check_regs("tv");

        // back-to-back WRITE then READ of the same register
        send(mk(8'hA5, 8'h01, 8'h05, 32'h0BADF00D));
        send(mk(8'hA5, 8'h02, 8'h05, 32'h0));
        wait_drain("b2b_drain");
        check_cnts("b2b");

        // random bursts, short enough that the queue never fills
        rdy_rand = 1'b1;
        for (int b = 0; b < 12; b++) begin
            n = $urandom_range(1, 12);
            for (int k = 0; k < n; k++) begin
                r = $urandom_range(0, 9);
                w = mk(8'hA5, (r < 4) ? 8'h01 : (r < 7) ? 8'h02 : (r == 7) ? 8'h03 :
                              (r == 8) ? 8'h04 : 8'($urandom_range(0, 255)),
                       8'($urandom_range(0, 19)), $urandom);
                if ($urandom_range(0, 9) == 0) w[63:56] = 8'h00;
                if ($urandom_range(0, 9) == 0) w = w ^ 64'h1;
                send(w, $urandom_range(0, 7) != 0);
                if ($urandom_range(0, 2) == 0) idle(1);
            end
            wait_drain($sformatf("rnd%0d_drain", b));
            check_cnts($sformatf("rnd%0d", b));
            check_regs($sformatf("rnd%0d", b));
        end
        rdy_rand = 1'b0; idle(1); rdy = 1'b1;

        // clear stats so the overflow run starts from zero
        send(mk(8'hA5, 8'h04, 8'h00, 32'h0));
        wait_drain("clr0_drain");
        check_cnts("clr0");

        // overflow: 20 PINGs with ready low, 16 kept, 4 dropped
        rdy = 1'b0;
        for (int k = 0; k < 20; k++) send(mk(8'hA5, 8'h03, 8'(k), 32'h1000 + k));
        idle(4);
        chk("ovf_drop_cnt", 64'(drop_cnt), 64'd4);
        chk("ovf_cmd_cnt", 64'(cmd_cnt), 64'(m_cmd));
        for (int c = 0; c < 3; c++) begin
            chk("ovf_hold_vld", 64'(rsp_tvalid), 64'd1);
            chk("ovf_hold_data", rsp_tdata, exp_q[0]);
            idle(1);
        end
        rdy = 1'b1;
        wait_drain("ovf_drain");
        send(mk(8'hA5, 8'h04, 8'h00, 32'h0));
        wait_drain("clr1_drain");
        chk("clr1_drop_cnt", 64'(drop_cnt), 64'd0);
        chk("clr1_err_cnt", 64'(err_cnt), 64'd0);

        // channel down: valid words are ignored
        for (int k = 0; k < 5; k++) begin
            send(mk(8'hA5, 8'h01, 8'h01, $urandom), 1'b0);
            idle(1);
        end
        idle(4);
        chk("cdown_rsp_vld", 64'(rsp_tvalid), 64'd0);
        check_cnts("cdown");
        check_regs("cdown");

        // reset in the middle of a burst
        rdy = 1'b0;
        for (int k = 0; k < 6; k++) send(mk(8'hA5, 8'h01, 8'(k), 32'hA0 + k));
        rxd = mk(8'hA5, 8'h01, 8'h07, 32'h77); rxv = 1'b1;
        rstn = 1'b0;
        #1;
        exp_q.delete();
        for (int i = 0; i < RC; i++) m_regs[i] = '0;
        m_cmd = 0; m_err = 0; m_drop = 0;
        chk("mrst_rsp_vld", 64'(rsp_tvalid), 64'd0);
        chk("mrst_rsp_data", rsp_tdata, 64'd0);
        chk("mrst_strobe", 64'(wr_strobe), 64'd0);
        check_cnts("mrst");
        check_regs("mrst");
        rxv = 1'b0;
        idle(2);
        rstn = 1'b1;
        idle(4);
        chk("post_rst_rsp_vld", 64'(rsp_tvalid), 64'd0);
        check_cnts("post_rst");

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
